// File: rtl/score_digit_renderer_pkg.sv
// Shared types and constants for the score digit renderer.
// The optional macro SCORE_LEADING_ZERO_BLANK_EN is consumed by the top level.
package score_pkg;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 32;
    localparam int RGB_W   = 12;

    localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 12'hFFF;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } score_t;

    // Stage-1 pipeline word, aligned with the ROM's returned colour.
    typedef struct packed {
        logic             in_rgn;
        logic             video_on;
        logic [RGB_W-1:0] bg;
    } stage1_t;

    function automatic bcd_t pick_digit(score_t s, logic digit_idx);
        return digit_idx ? s.units : s.tens;
    endfunction

endpackage

// File: rtl/score_digit_renderer_if.sv
// Address/data bus between the renderer and the digit glyph ROM bank.
interface score_glyph_if;
    import score_pkg::*;

    bcd_t             glyph_sel;
    logic [4:0]       glyph_row;
    logic [4:0]       glyph_col;
    logic [RGB_W-1:0] glyph_rgb;

    modport master (output glyph_sel, output glyph_row, output glyph_col, input  glyph_rgb);
    modport slave  (input  glyph_sel, input  glyph_row, input  glyph_col, output glyph_rgb);

endinterface

// File: rtl/score_digit_renderer_bcd_counter.sv
// Two-digit BCD score counter, 00..99, saturating; clear beats increment.
module score_bcd_counter
    import score_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    input  logic   clr,
    output score_t score
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (inc) begin
            if (score.tens == 4'd9 && score.units == 4'd9) begin
                score <= score;
            end else if (score.units == 4'd9) begin
                score.tens  <= score.tens + 4'd1;
                score.units <= 4'd0;
            end else begin
                score.units <= score.units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score overlay: per-frame score latch, glyph ROM addressing and a 2-stage colour mixer.
// Optional: SCORE_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module score_digit_renderer
    import score_pkg::*;
#(
    parameter int X0 = 560,
    parameter int Y0 = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             video_on,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic [RGB_W-1:0] bg_rgb,
    input  logic             frame_tick,
    input  logic             score_inc,
    input  logic             score_clr,
    score_glyph_if.master    rom,
    output logic [RGB_W-1:0] rgb_out,
    output logic [7:0]       score_bcd
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 2 * GLYPH_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + GLYPH_H);

    score_t  score;
    score_t  shown;
    stage1_t s1;

    logic [5:0] dx;
    logic [4:0] dy;
    logic       digit_idx;
    logic       in_box;
    logic       in_rgn;

    score_bcd_counter u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (score_inc),
        .clr   (score_clr),
        .score (score)
    );

    assign score_bcd = score;

    // Latches the pre-update score when frame_tick coincides with inc/clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          shown <= '0;
        else if (frame_tick) shown <= score;
    end

    assign dx        = 6'(pixel_x - 10'(X0));
    assign dy        = 5'(pixel_y - 10'(Y0));
    assign digit_idx = dx[5];
    assign in_box    = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                       ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign in_rgn = in_box && !(!digit_idx && shown.tens == 4'd0);
`else
    assign in_rgn = in_box;
`endif

    assign rom.glyph_sel = pick_digit(shown, digit_idx);
    assign rom.glyph_row = dy;
    assign rom.glyph_col = dx[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            rgb_out <= '0;
        end else begin
            s1.in_rgn   <= in_rgn;
            s1.video_on <= video_on;
            s1.bg       <= bg_rgb;
            if (!s1.video_on)
                rgb_out <= '0;
            else if (s1.in_rgn && rom.glyph_rgb != TRANSPARENT_RGB)
                rgb_out <= rom.glyph_rgb;
            else
                rgb_out <= s1.bg;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed bench: pixel stimulus pushes expected colours, a monitor checks them 2 cycles later.
module tb_score_digit_renderer;
    import score_pkg::*;

    localparam int X0 = 560;
    localparam int Y0 = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic [11:0] bg_rgb = '0;
    logic        frame_tick = 1'b0;
    logic        score_inc = 1'b0;
    logic        score_clr = 1'b0;
    logic [11:0] rgb_out;
    logic [7:0]  score_bcd;
    logic [11:0] rom_next = '0;

    score_glyph_if rif ();

    score_digit_renderer #(.X0(X0), .Y0(Y0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .bg_rgb     (bg_rgb),
        .frame_tick (frame_tick),
        .score_inc  (score_inc),
        .score_clr  (score_clr),
        .rom        (rif.master),
        .rgb_out    (rgb_out),
        .score_bcd  (score_bcd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: colour for the address presented in one cycle appears the next.
    always @(posedge clk) rif.glyph_rgb <= rom_next;

    typedef struct {
        int          issue;
        logic [11:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] tens0_exp(logic [11:0] bg, logic [11:0] rom_v);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        return bg;
`else
        return (rom_v == 12'hFFF) ? bg : rom_v;
`endif
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].issue + 2 <= cyc) begin
                e = q.pop_front();
                if (e.issue + 2 < cyc) check({e.name, "_late"}, 32'd1, 32'd0);
                else                   check(e.name, rgb_out, e.exp);
            end
        end
    end

    // gmode: 0 = no address check, 1 = check sel/row/col, 2 = check they are driven
    task automatic pix(int x, int y, logic von, logic [11:0] bg, logic [11:0] rom_v,
                       logic [11:0] exp, string name,
                       int gmode = 0, int esel = 0, int erow = 0, int ecol = 0);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        bg_rgb   = bg;
        rom_next = rom_v;
        q.push_back('{cyc, exp, name});
        #1;
        if (gmode == 1) begin
            check({name, "_sel"}, 32'(rif.glyph_sel), 32'(esel));
            check({name, "_row"}, 32'(rif.glyph_row), 32'(erow));
            check({name, "_col"}, 32'(rif.glyph_col), 32'(ecol));
        end else if (gmode == 2) begin
            check({name, "_drv"}, 32'($isunknown({rif.glyph_sel, rif.glyph_row, rif.glyph_col})), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic pulse(logic inc, logic clr, logic ft);
        score_inc  = inc;
        score_clr  = clr;
        frame_tick = ft;
        @(negedge clk);
        score_inc  = 1'b0;
        score_clr  = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        video_on = 1'b1;
        pixel_x  = 10'd10;
        pixel_y  = 10'd300;
        bg_rgb   = 12'h123;
        repeat (3) @(negedge clk);
        check("rst_score", score_bcd, 32'h00);
        check("rst_rgb", rgb_out, 32'h000);
        q.push_back('{cyc - 1, 12'h000, "rst_rel0"});
        rst_n = 1'b1;
        pix(10, 300, 1'b1, 12'h123, 12'h000, 12'h123, "rst_rel1");

        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
        check("score12", score_bcd, 32'h12);
        pix(X0 + 5, Y0 + 2, 1'b1, 12'h111, 12'h00F, tens0_exp(12'h111, 12'h00F),
            "shown_pre_tick", 1, 0, 2, 5);
        pulse(1'b0, 1'b0, 1'b1);
        pix(X0 + 31, Y0, 1'b1, 12'h222, 12'h0AB, 12'h0AB, "tens_edge", 1, 1, 0, 31);
        pix(X0 + 32, Y0, 1'b1, 12'h333, 12'hFFF, 12'h333, "units_edge_transp", 1, 2, 0, 0);

        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 99; i++) pulse(1'b1, 1'b0, 1'b0);
        check("score99", score_bcd, 32'h99);
        pulse(1'b1, 1'b0, 1'b0);
        check("sat99", score_bcd, 32'h99);
        pulse(1'b1, 1'b1, 1'b0);
        check("clr_prio", score_bcd, 32'h00);

        for (int i = 0; i < 47; i++) pulse(1'b1, 1'b0, 1'b0);
        check("score47", score_bcd, 32'h47);
        pulse(1'b0, 1'b0, 1'b1);
        pix(X0 + 37, Y0 + 3, 1'b1, 12'h0F0, 12'h000, 12'h000, "glyph_black", 1, 7, 3, 5);
        pix(X0 + 40, Y0 + 10, 1'b1, 12'h0F0, 12'hFFF, 12'h0F0, "transparent", 1, 7, 10, 8);
        pix(X0 + 64, Y0, 1'b1, 12'h0A5, 12'h123, 12'h0A5, "right_out", 2);
        pix(X0 - 1, Y0 + 5, 1'b1, 12'h0A6, 12'h456, 12'h0A6, "left_out", 2);
        pix(X0 + 10, Y0 + 32, 1'b1, 12'h0A7, 12'h456, 12'h0A7, "below_out", 2);
        pix(X0 + 10, Y0 - 1, 1'b1, 12'h0A9, 12'h456, 12'h0A9, "above_out", 2);
        pix(X0 + 63, Y0 + 31, 1'b1, 12'h0A8, 12'h321, 12'h321, "corner_in", 1, 7, 31, 31);
        pix(X0, Y0, 1'b1, 12'h0A8, 12'h654, 12'h654, "origin_in", 1, 4, 0, 0);
        pix(X0 + 40, Y0 + 5, 1'b0, 12'h0F0, 12'h456, 12'h000, "blank_in");
        pix(100, 200, 1'b0, 12'h0F0, 12'h456, 12'h000, "blank_out");

        pulse(1'b1, 1'b0, 1'b0);
        check("score48", score_bcd, 32'h48);
        pulse(1'b1, 1'b0, 1'b1);
        check("score49", score_bcd, 32'h49);
        pix(X0 + 33, Y0 + 1, 1'b1, 12'h111, 12'h0C0, 12'h0C0, "tick_old", 1, 8, 1, 1);
        pulse(1'b0, 1'b0, 1'b1);
        pix(X0 + 33, Y0 + 1, 1'b1, 12'h111, 12'h0C0, 12'h0C0, "tick_new", 1, 9, 1, 1);

        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
        check("score05", score_bcd, 32'h05);
        pulse(1'b0, 1'b0, 1'b1);
        pix(X0 + 2, Y0 + 1, 1'b1, 12'h111, 12'h00F, tens0_exp(12'h111, 12'h00F),
            "tens_zero", 1, 0, 1, 2);
        pix(X0 + 33, Y0 + 1, 1'b1, 12'h111, 12'h0F0, 12'h0F0, "units_five", 1, 5, 1, 1);

        repeat (3) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
